// File: rtl/uart_rx_deser_if.sv
// Byte-side bundle of the UART receive deserializer: serial input plus received byte and strobes.
// With UART_RX_PARITY_EN defined the bundle also carries parity_err.
interface uart_rx_deser_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport master (input rx, output data, output valid, output frame_err, output parity_err);
    modport slave  (output rx, input data, input valid, input frame_err, input parity_err);
`else
    modport master (input rx, output data, output valid, output frame_err);
    modport slave  (output rx, input data, input valid, input frame_err);
`endif
endinterface

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer with mid-bit sampling; presents each byte as a one-cycle valid strobe.
// Optional feature macro UART_RX_PARITY_EN switches the frame to 8E1 and adds parity_err.
module uart_rx_deser #(
    parameter int CLK_FREQ = 50,
    parameter int BIT_RATE = 115200
) (
    input  logic             clk,
    input  logic             resetn,
    uart_rx_deser_if.master  bus
);
    localparam int BIT_CYC = (CLK_FREQ * 1000000) / BIT_RATE;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CW      = $clog2(BIT_CYC);

    localparam logic [CW-1:0] C_FULL = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (BIT_CYC < 8) begin : g_bit_cyc_check
        $error("uart_rx_deser: BIT_CYC must be at least 8");
    end

    logic          r_sync1;
    logic          r_rx_s;
    logic          r_rx_d;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          w_fall;
    logic          w_full;
    logic          w_half;

`ifdef UART_RX_PARITY_EN
    logic          r_par;
    logic          r_perr;

    // Even parity: the data bits and the parity bit together must hold an even number of ones.
    function automatic logic par_bad_f(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    // Two-flop synchronizer on the pin plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // Start-edge detect and counter terminal counts.
    always_comb begin
        w_fall = r_rx_d & ~r_rx_s;
        w_full = (r_cnt == C_FULL);
        w_half = (r_cnt == C_HALF);
    end

    // Frame FSM; the stop bit is judged at its midpoint so a following start bit is not missed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (w_half) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_par   <= r_rx_s;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (!r_rx_s) begin
                            r_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_f(r_shift, r_par)) begin
                            r_perr <= 1'b1;
`endif
                        end else begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_perr;
`endif
endmodule
